// File: rtl/syndrome_byte_serializer.sv
// Serializes GRID_WIDTH_U measurement rounds into a header-led 8-bit valid/ready byte stream.
// Optional per-round tag bytes are enabled by defining SYNDROME_SERIALIZER_ROUND_TAG_EN.
module syndrome_byte_serializer #(
   parameter int         GRID_WIDTH_X      = 4,
   parameter int         GRID_WIDTH_Z      = 1,
   parameter int         GRID_WIDTH_U      = 5,
   parameter logic [7:0] HEADER_BYTE       = 8'hA5,
   parameter int         FRAME_COUNT_WIDTH = 16
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [GRID_WIDTH_X*GRID_WIDTH_Z-1:0] meas_data,
   input  logic                                 meas_valid,
   output logic                                 meas_ready,
   output logic [7:0]                           out_data,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic                                 frame_busy,
   output logic [FRAME_COUNT_WIDTH-1:0]         frames_sent
);

   localparam int PR    = GRID_WIDTH_X * GRID_WIDTH_Z;
   localparam int BPR   = (PR + 7) / 8;
   localparam int BUF_W = BPR * 8;
   localparam int RW    = (GRID_WIDTH_U > 1) ? $clog2(GRID_WIDTH_U) : 1;
   localparam int BW    = (BPR > 1) ? $clog2(BPR) : 1;
   localparam logic [RW-1:0] LAST_ROUND = RW'(GRID_WIDTH_U - 1);
   localparam logic [BW-1:0] LAST_BYTE  = BW'(BPR - 1);

`ifdef SYNDROME_SERIALIZER_ROUND_TAG_EN
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HEADER = 2'd1, ST_PAYLOAD = 2'd2, ST_TAG = 2'd3} state_t;
   localparam state_t BODY_ST = ST_TAG;
`else
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HEADER = 2'd1, ST_PAYLOAD = 2'd2} state_t;
   localparam state_t BODY_ST = ST_PAYLOAD;
`endif

   state_t                       state_q, state_d;
   logic [BUF_W-1:0]             buf_q, buf_d;
   logic [RW-1:0]                round_q, round_d;
   logic [BW-1:0]                byte_q, byte_d;
   logic                         busy_q, busy_d;
   logic [FRAME_COUNT_WIDTH-1:0] frames_q, frames_d;
   logic [7:0]                   payload_byte_s;

   assign frame_busy  = busy_q;
   assign frames_sent = frames_q;

   // Byte-lane select of the round buffer; padding above PR is zero from capture
   always_comb begin
      payload_byte_s = 8'h00;
      for (int b = 0; b < BPR; b++) begin
         payload_byte_s = (byte_q == BW'(b)) ? buf_q[8*b +: 8] : payload_byte_s;
      end
   end

   // Next-state and handshake outputs; reset forces all outputs low
   always_comb begin
      state_d    = state_q;
      buf_d      = buf_q;
      round_d    = round_q;
      byte_d     = byte_q;
      busy_d     = busy_q;
      frames_d   = frames_q;
      meas_ready = 1'b0;
      out_valid  = 1'b0;
      out_data   = 8'h00;
      if (reset) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               meas_ready = 1'b1;
               if (meas_valid) begin
                  buf_d   = BUF_W'(meas_data);
                  byte_d  = '0;
                  state_d = (round_q == '0) ? ST_HEADER : BODY_ST;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_HEADER: begin
               out_valid = 1'b1;
               out_data  = HEADER_BYTE;
               if (out_ready) begin
                  state_d = BODY_ST;
                  busy_d  = 1'b1;
               end else begin
                  state_d = ST_HEADER;
               end
            end
`ifdef SYNDROME_SERIALIZER_ROUND_TAG_EN
            ST_TAG: begin
               out_valid = 1'b1;
               out_data  = {1'b1, 7'(round_q)};
               if (out_ready) begin
                  state_d = ST_PAYLOAD;
               end else begin
                  state_d = ST_TAG;
               end
            end
`endif
            ST_PAYLOAD: begin
               out_valid = 1'b1;
               out_data  = payload_byte_s;
               if (!out_ready) begin
                  state_d = ST_PAYLOAD;
               end else if (byte_q != LAST_BYTE) begin
                  byte_d = byte_q + BW'(1);
               end else begin
                  // Last byte of the round leaves: a waiting round chains in with no bubble
                  meas_ready = 1'b1;
                  if (round_q == LAST_ROUND) begin
                     round_d  = '0;
                     frames_d = frames_q + FRAME_COUNT_WIDTH'(1);
                     busy_d   = 1'b0;
                  end else begin
                     round_d = round_q + RW'(1);
                  end
                  if (meas_valid) begin
                     buf_d   = BUF_W'(meas_data);
                     byte_d  = '0;
                     state_d = (round_d == '0) ? ST_HEADER : BODY_ST;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         buf_q    <= '0;
         round_q  <= '0;
         byte_q   <= '0;
         busy_q   <= 1'b0;
         frames_q <= '0;
      end else begin
         state_q  <= state_d;
         buf_q    <= buf_d;
         round_q  <= round_d;
         byte_q   <= byte_d;
         busy_q   <= busy_d;
         frames_q <= frames_d;
      end
   end

endmodule
